micro_code_queue: RTL and testbench

Parametrised decoupling queue for `MicroCode` bundles between the decode and execute stages of the RV32I pipeline. It generalises the single per-stage pipeline register to a DEPTH-entry circular FIFO with valid/ready handshakes on both sides, a whole-queue flush for branch/exception redirect, an occupancy count, and a pending-destination mask for hazard detection in decode. Decode enqueues one bundle per cycle and execute dequeues one bundle per cycle.

---
 rtl/micro_code_queue_if.sv | 52 +++++
 rtl/micro_code_queue.sv | 125 ++++++++++++
 tb/tb_micro_code_queue.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/micro_code_queue_if.sv
// micro_code_queue_if
// Handshake bundle between decode (master) and the micro_code_queue (slave).
//   enq_valid/enq_ready/enq_code : decode -> queue push side
//   deq_valid/deq_ready/deq_code : queue -> execute pop side
//   flush                        : redirect, discards everything queued
//   count                        : occupancy, $clog2(DEPTH)+1 bits
//   pending_rd                   : destinations still sitting in the queue
// The MicroCode bundle type lives in micro_code_pkg. The package text is
// guarded so that this file and micro_code_queue.sv may be parsed in either order.

`ifndef MICRO_CODE_PKG_DEFINED
`define MICRO_CODE_PKG_DEFINED
package micro_code_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        rs1_en;
        logic [4:0]  rs1_addr;
        logic        rs2_en;
        logic [4:0]  rs2_addr;
        logic        rd_en;
        logic [4:0]  rd_addr;
    } MicroCode;
endpackage
`endif

interface micro_code_queue_if #(
    parameter int DEPTH = 4
);
    import micro_code_pkg::*;

    logic                     enq_valid;
    logic                     enq_ready;
    MicroCode                 enq_code;
    logic                     deq_valid;
    logic                     deq_ready;
    MicroCode                 deq_code;
    logic                     flush;
    logic [$clog2(DEPTH):0]   count;
    logic [31:0]              pending_rd;

    modport master (
        output enq_valid, enq_code, deq_ready, flush,
        input  enq_ready, deq_valid, deq_code, count, pending_rd
    );

    modport slave (
        input  enq_valid, enq_code, deq_ready, flush,
        output enq_ready, deq_valid, deq_code, count, pending_rd
    );
endinterface

// File: rtl/micro_code_queue.sv
// micro_code_queue
// DEPTH-entry circular FIFO of MicroCode bundles between decode and execute.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous active-high reset (entries discarded, storage kept)
//   bus  : micro_code_queue_if.slave (enqueue, dequeue, flush, count, pending_rd)
// Optional feature: define MICRO_CODE_QUEUE_BYPASS_EN to let a bundle offered
// to an empty queue appear on deq_* in the same cycle (0-cycle latency).
// Without it there is no combinational path from enq_* to deq_*.
// DEPTH must be a power of two and >= 2 so the pointers wrap naturally.

`ifndef MICRO_CODE_PKG_DEFINED
`define MICRO_CODE_PKG_DEFINED
package micro_code_pkg;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [3:0]  alu_op;
        logic        rs1_en;
        logic [4:0]  rs1_addr;
        logic        rs2_en;
        logic [4:0]  rs2_addr;
        logic        rd_en;
        logic [4:0]  rd_addr;
    } MicroCode;
endpackage
`endif

module micro_code_queue #(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    micro_code_queue_if.slave   bus
);
    import micro_code_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    MicroCode          mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;

    logic              full_s;
    logic              empty_s;
    logic              enq_fire_s;
    logic              deq_fire_s;
    logic              byp_s;      // empty queue offered a bundle (bypass builds only)
    logic              through_s;  // bypassed bundle consumed, nothing stored
    logic              push_s;
    logic              pop_s;
    logic [31:0]       pending_s;

    // Handshake decode: ready/valid, output mux and the push/pop strobes.
    always_comb begin
        full_s        = (count_r == CW'(DEPTH));
        empty_s       = (count_r == {CW{1'b0}});
        // enq_ready deliberately ignores deq_ready: a full queue never refills in the same cycle.
        bus.enq_ready = !full_s && !bus.flush && !rst;
`ifdef MICRO_CODE_QUEUE_BYPASS_EN
        byp_s         = empty_s && bus.enq_valid && !bus.flush && !rst;
        bus.deq_valid = (!empty_s || bus.enq_valid) && !bus.flush && !rst;
        if (empty_s) begin
            bus.deq_code = bus.enq_code;
        end else begin
            bus.deq_code = mem_r[rd_ptr_r];
        end
`else
        byp_s         = 1'b0;
        bus.deq_valid = !empty_s && !bus.flush && !rst;
        bus.deq_code  = mem_r[rd_ptr_r];
`endif
        enq_fire_s = bus.enq_valid && bus.enq_ready;
        deq_fire_s = bus.deq_valid && bus.deq_ready;
        through_s  = byp_s && bus.deq_ready;
        push_s     = enq_fire_s && !through_s;
        pop_s      = deq_fire_s && !through_s;
        bus.count  = count_r;
    end

    // Pending-destination mask over the occupied slots rd_ptr .. rd_ptr+count-1.
    always_comb begin
        pending_s = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            pending_s = pending_s |
                (((CW'(i) < count_r) && mem_r[rd_ptr_r + AW'(i)].rd_en) ?
                    (32'd1 << mem_r[rd_ptr_r + AW'(i)].rd_addr) : 32'd0);
        end
        pending_s[0]   = 1'b0;  // x0 is never a real hazard
        bus.pending_rd = pending_s;
    end

    // Pointer and occupancy state; flush rewinds rd_ptr onto wr_ptr.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else if (bus.flush) begin
            rd_ptr_r <= wr_ptr_r;
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; never reset, push_s is already blocked by flush and rst.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= bus.enq_code;
        end
    end
endmodule

// File: tb/tb_micro_code_queue.sv
module tb_micro_code_queue;
    logic clk;
    logic rst;
    int   tests;
    int   fails;

    micro_code_queue_if #(.DEPTH(4)) bus ();

    micro_code_queue #(.DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic [31:0] pc;
        logic        rden;
        logic [4:0]  rda;
        logic        dr;
        logic        fl;
        logic        er;
        logic        dv;
        logic [31:0] dpc;
        logic [2:0]  cnt;
        logic [31:0] pend;
    } vec_t;

    vec_t vecs [30];

    function automatic vec_t mk(logic ev, logic [31:0] pc, logic rden, logic [4:0] rda,
                                logic dr, logic fl, logic er, logic dv, logic [31:0] dpc,
                                logic [2:0] cnt, logic [31:0] pend);
        vec_t v;
        v.ev = ev; v.pc = pc; v.rden = rden; v.rda = rda; v.dr = dr; v.fl = fl;
        v.er = er; v.dv = dv; v.dpc = dpc; v.cnt = cnt; v.pend = pend;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [31:0] pc, input logic rden,
                         input logic [4:0] rda, input logic dr, input logic fl, input logic r);
        bus.enq_valid        = ev;
        bus.enq_code         = '0;
        bus.enq_code.pc      = pc;
        bus.enq_code.rd_en   = rden;
        bus.enq_code.rd_addr = rda;
        bus.deq_ready        = dr;
        bus.flush            = fl;
        rst                  = r;
    endtask

    initial begin
        vec_t v;
        logic exp_dv;
        logic [31:0] exp_dpc;
        tests = 0;
        fails = 0;

        // fill to full, refuse while full, drain with wrap
        vecs[0]  = mk(1'b1, 32'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 3'd0, 32'h0);
        vecs[1]  = mk(1'b1, 32'h04, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00, 3'd1, 32'h0);
        vecs[2]  = mk(1'b1, 32'h08, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00, 3'd2, 32'h0);
        vecs[3]  = mk(1'b1, 32'h0C, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h00, 3'd3, 32'h0);
        vecs[4]  = mk(1'b1, 32'h10, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h00, 3'd4, 32'h0);
        vecs[5]  = mk(1'b1, 32'h10, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h00, 3'd4, 32'h0);
        vecs[6]  = mk(1'b1, 32'h10, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h04, 3'd3, 32'h0);
        vecs[7]  = mk(1'b1, 32'h14, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h08, 3'd3, 32'h0);
        vecs[8]  = mk(1'b0, 32'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0C, 3'd3, 32'h0);
        vecs[9]  = mk(1'b0, 32'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 3'd2, 32'h0);
        vecs[10] = mk(1'b0, 32'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h14, 3'd1, 32'h0);
        vecs[11] = mk(1'b0, 32'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 3'd0, 32'h0);
        // simultaneous enqueue + dequeue at count 2
        vecs[12] = mk(1'b1, 32'h20, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 3'd0, 32'h0);
        vecs[13] = mk(1'b1, 32'h24, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h20, 3'd1, 32'h0);
        vecs[14] = mk(1'b1, 32'h28, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h20, 3'd2, 32'h0);
        vecs[15] = mk(1'b1, 32'h2C, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h24, 3'd2, 32'h0);
        vecs[16] = mk(1'b0, 32'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h28, 3'd2, 32'h0);
        vecs[17] = mk(1'b0, 32'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h2C, 3'd1, 32'h0);
        vecs[18] = mk(1'b0, 32'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 3'd0, 32'h0);
        // pending mask: rd 5 (en), rd 0 (en), rd 9 (not en)
        vecs[19] = mk(1'b1, 32'h30, 1'b1, 5'd5, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 3'd0, 32'h0);
        vecs[20] = mk(1'b1, 32'h34, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h30, 3'd1, 32'h20);
        vecs[21] = mk(1'b1, 32'h38, 1'b0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b1, 32'h30, 3'd2, 32'h20);
        vecs[22] = mk(1'b0, 32'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h30, 3'd3, 32'h20);
        vecs[23] = mk(1'b0, 32'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h34, 3'd2, 32'h0);
        // reach count 3 then flush with an enqueue offered
        vecs[24] = mk(1'b1, 32'h3C, 1'b1, 5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 32'h34, 3'd2, 32'h0);
        vecs[25] = mk(1'b1, 32'h50, 1'b1, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 3'd3, 32'h80);
        vecs[26] = mk(1'b0, 32'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 3'd0, 32'h0);
        vecs[27] = mk(1'b1, 32'h40, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 3'd0, 32'h0);
        vecs[28] = mk(1'b0, 32'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h40, 3'd1, 32'h0);
        vecs[29] = mk(1'b0, 32'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 3'd0, 32'h0);

        // reset held two edges with enq_valid high
        drive(1'b1, 32'hAA, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        #2;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_deq_valid", 32'(bus.deq_valid), 32'd0);
        chk("rst_enq_ready", 32'(bus.enq_ready), 32'd0);
        chk("rst_pending", bus.pending_rd, 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("rel_enq_ready", 32'(bus.enq_ready), 32'd1);
        chk("rel_count", 32'(bus.count), 32'd0);
        chk("rel_deq_valid", 32'(bus.deq_valid), 32'd0);

        for (int i = 0; i < 30; i++) begin
            v = vecs[i];
            @(negedge clk);
            drive(v.ev, v.pc, v.rden, v.rda, v.dr, v.fl, 1'b0);
            exp_dv  = v.dv;
            exp_dpc = v.dpc;
`ifdef MICRO_CODE_QUEUE_BYPASS_EN
            if (v.cnt == 3'd0 && v.ev && !v.fl) begin
                exp_dv  = 1'b1;
                exp_dpc = v.pc;
            end
`endif
            #2;
            chk($sformatf("v%0d_enq_ready", i), 32'(bus.enq_ready), 32'(v.er));
            chk($sformatf("v%0d_deq_valid", i), 32'(bus.deq_valid), 32'(exp_dv));
            chk($sformatf("v%0d_count", i), 32'(bus.count), 32'(v.cnt));
            chk($sformatf("v%0d_pending", i), bus.pending_rd, v.pend);
            if (exp_dv) begin
                chk($sformatf("v%0d_deq_pc", i), bus.deq_code.pc, exp_dpc);
            end
        end

        // reset in the middle of operation discards queued entries
        @(negedge clk);
        drive(1'b1, 32'h60, 1'b1, 5'd12, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h64, 1'b1, 5'd13, 1'b0, 1'b0, 1'b1);
        #2;
        chk("midrst_enq_ready", 32'(bus.enq_ready), 32'd0);
        chk("midrst_deq_valid", 32'(bus.deq_valid), 32'd0);
        chk("midrst_pending_before", bus.pending_rd, 32'h0000_1000);
        @(negedge clk);
        drive(1'b0, 32'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        #2;
        chk("midrst_count", 32'(bus.count), 32'd0);
        chk("midrst_enq_ready_after", 32'(bus.enq_ready), 32'd1);
        chk("midrst_deq_valid_after", 32'(bus.deq_valid), 32'd0);
        chk("midrst_pending_after", bus.pending_rd, 32'h0);

        // empty queue, offer and consume in the same cycle
        @(negedge clk);
        drive(1'b1, 32'h80, 1'b1, 5'd2, 1'b1, 1'b0, 1'b0);
        #2;
`ifdef MICRO_CODE_QUEUE_BYPASS_EN
        chk("byp_deq_valid", 32'(bus.deq_valid), 32'd1);
        chk("byp_deq_pc", bus.deq_code.pc, 32'h80);
        chk("byp_pending", bus.pending_rd, 32'h0);
        @(negedge clk);
        drive(1'b0, 32'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        #2;
        chk("byp_count_after", 32'(bus.count), 32'd0);
        chk("byp_deq_valid_after", 32'(bus.deq_valid), 32'd0);
`else
        chk("nobyp_deq_valid", 32'(bus.deq_valid), 32'd0);
        @(negedge clk);
        drive(1'b0, 32'h00, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        #2;
        chk("nobyp_deq_valid_next", 32'(bus.deq_valid), 32'd1);
        chk("nobyp_deq_pc_next", bus.deq_code.pc, 32'h80);
        chk("nobyp_count_next", 32'(bus.count), 32'd1);
        chk("nobyp_pending_next", bus.pending_rd, 32'h4);
        @(negedge clk);
        drive(1'b0, 32'h00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        chk("nobyp_count_drained", 32'(bus.count), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
